// File: rtl/mem_burst_rd_responder.sv
// Line-read responder: accepts one 32-byte line request, then streams the 8 words of that
// line from an internal word memory, lowest word first. A side port preloads the memory.
module mem_burst_rd_responder #(
    parameter int MEM_WORDS_LOG2 = 12,
    parameter int REQ_LATENCY    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      from_cache_rd_req_valid,
    input  logic [31:0]               from_cache_rd_req_addr,
    output logic                      to_cache_rd_req_ready,
    output logic                      to_cache_rd_rsp_valid,
    output logic [31:0]               to_cache_rd_rsp_data,
    output logic                      to_cache_rd_rsp_last,
    input  logic                      from_cache_rd_rsp_ready,
    input  logic                      init_wen,
    input  logic [MEM_WORDS_LOG2-1:0] init_addr,
    input  logic [31:0]               init_data,
    output logic [31:0]               burst_count
);
    localparam int LINE_W = MEM_WORDS_LOG2 - 3;

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t                    state, state_nxt;
    logic [LINE_W-1:0]         line_q, line_nxt;
    logic [2:0]                beat_q, beat_nxt;
    logic [7:0]                lat_q, lat_nxt;
    logic [31:0]               rsp_data_q;
    logic [31:0]               burst_count_q;
    logic                      load_en;
    logic [MEM_WORDS_LOG2-1:0] load_addr;
    logic                      bc_inc;
    logic                      accept;
    logic [LINE_W-1:0]         req_line;

    logic [31:0] mem [2**MEM_WORDS_LOG2];

    // Offset bits and bits above the memory size are dropped, so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{from_cache_rd_req_addr[31:MEM_WORDS_LOG2+2],
                                from_cache_rd_req_addr[4:0]};

    assign req_line              = from_cache_rd_req_addr[MEM_WORDS_LOG2+1:5];
    assign to_cache_rd_req_ready = (state == IDLE) && !rst;
    assign to_cache_rd_rsp_valid = (state == SEND);
    assign to_cache_rd_rsp_last  = (state == SEND) && (beat_q == 3'd7);
    assign to_cache_rd_rsp_data  = rsp_data_q;
    assign burst_count           = burst_count_q;
    assign accept                = from_cache_rd_req_valid && to_cache_rd_req_ready;

    always_comb begin
        state_nxt = state;
        line_nxt  = line_q;
        beat_nxt  = beat_q;
        lat_nxt   = lat_q;
        load_en   = 1'b0;
        load_addr = {line_q, beat_q + 3'd1};
        bc_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    line_nxt = req_line;
                    beat_nxt = 3'd0;
                    if (REQ_LATENCY == 0) begin
                        load_en   = 1'b1;
                        load_addr = {req_line, 3'd0};
                        state_nxt = SEND;
                    end else begin
                        lat_nxt   = 8'(REQ_LATENCY);
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                lat_nxt = lat_q - 8'd1;
                if (lat_q == 8'd1) begin
                    load_en   = 1'b1;
                    load_addr = {line_q, 3'd0};
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (from_cache_rd_rsp_ready) begin
                    if (beat_q == 3'd7) begin
                        bc_inc    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        load_en  = 1'b1;
                        beat_nxt = beat_q + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The data register samples mem before this cycle's preload write lands (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            line_q        <= '0;
            beat_q        <= 3'd0;
            lat_q         <= 8'd0;
            rsp_data_q    <= 32'd0;
            burst_count_q <= 32'd0;
        end else begin
            state  <= state_nxt;
            line_q <= line_nxt;
            beat_q <= beat_nxt;
            lat_q  <= lat_nxt;
            if (load_en) rsp_data_q <= mem[load_addr];
            if (bc_inc)  burst_count_q <= burst_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (init_wen) mem[init_addr] <= init_data;
    end

endmodule

// File: tb/tb_mem_burst_rd_responder.sv
// Bench for mem_burst_rd_responder: a latency-4 instance checked through a beat scoreboard,
// plus a latency-0 instance used for the preload read-before-write race.
module tb_mem_burst_rd_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid0;
    logic [31:0] req_addr;
    logic        req_ready, req_ready0;
    logic        rsp_valid, rsp_valid0;
    logic [31:0] rsp_data, rsp_data0;
    logic        rsp_last, rsp_last0;
    logic        rsp_ready;
    logic        init_wen;
    logic [11:0] init_addr;
    logic [31:0] init_data;
    logic [31:0] burst_count, burst_count0;

    always #5 clk = ~clk;

    mem_burst_rd_responder #(.MEM_WORDS_LOG2(12), .REQ_LATENCY(4)) u_dut (
        .clk(clk), .rst(rst),
        .from_cache_rd_req_valid(req_valid), .from_cache_rd_req_addr(req_addr),
        .to_cache_rd_req_ready(req_ready),
        .to_cache_rd_rsp_valid(rsp_valid), .to_cache_rd_rsp_data(rsp_data),
        .to_cache_rd_rsp_last(rsp_last), .from_cache_rd_rsp_ready(rsp_ready),
        .init_wen(init_wen), .init_addr(init_addr), .init_data(init_data),
        .burst_count(burst_count)
    );

    mem_burst_rd_responder #(.MEM_WORDS_LOG2(12), .REQ_LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .from_cache_rd_req_valid(req_valid0), .from_cache_rd_req_addr(req_addr),
        .to_cache_rd_req_ready(req_ready0),
        .to_cache_rd_rsp_valid(rsp_valid0), .to_cache_rd_rsp_data(rsp_data0),
        .to_cache_rd_rsp_last(rsp_last0), .from_cache_rd_rsp_ready(rsp_ready),
        .init_wen(init_wen), .init_addr(init_addr), .init_data(init_data),
        .burst_count(burst_count0)
    );

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [4096];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor for u_dut: checks every beat, hold-under-stall and last placement.
    int          mon_beat = 0;
    int          hs_cnt = 0;
    logic        have_prev = 1'b0;
    logic [31:0] prev_data;

    always @(negedge clk) begin
        if (rst) begin
            mon_beat  = 0;
            have_prev = 1'b0;
        end else if (rsp_valid) begin
            if (have_prev) chk("hold_data", rsp_data, prev_data);
            chk("last", rsp_last, mon_beat == 7);
            chk("rdy_busy", req_ready, 1'b0);
            if (rsp_ready) begin
                hs_cnt++;
                chk("beat_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) chk("beat_data", rsp_data, exp_q.pop_front());
                mon_beat  = (mon_beat + 1) % 8;
                have_prev = 1'b0;
            end else begin
                have_prev = 1'b1;
                prev_data = rsp_data;
            end
        end else if (have_prev) begin
            chk("hold_valid", rsp_valid, 1'b1);
            have_prev = 1'b0;
        end
    end

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        init_wen  = 1'b1;
        init_addr = a;
        init_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        init_wen = 1'b0;
    endtask

    task automatic push_line(input logic [31:0] a);
        for (int i = 0; i < 8; i++) exp_q.push_back(ref_mem[{a[13:5], 3'(i)}]);
    endtask

    task automatic do_req(input logic [31:0] a);
        logic ok;
        ok = 1'b0;
        push_line(a);
        req_valid = 1'b1;
        req_addr  = a;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("accept", ok, 1'b1);
    endtask

    task automatic drain(input bit bp);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            rsp_ready = bp ? ~rsp_ready : 1'b1;
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) ok = 1'b1;
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        chk("drain", ok, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int h0;
        int acc;
        logic [31:0] e;
        rst = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; req_addr = '0;
        rsp_ready = 1'b1; init_wen = 1'b0; init_addr = '0; init_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_last", rsp_last, 1'b0);
        chk("rst_burst_count", burst_count, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            wr(12'h040 + 12'(i), 32'hA0 + 32'(i));
            wr(12'h080 + 12'(i), $urandom);
            wr(12'h100 + 12'(i), 32'hB0 + 32'(i));
        end

        // Directed: accept is cycle 0, beats in cycles 5..12, ready again at 13.
        do_req(32'h0000_0100);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            chk($sformatf("t1_valid_c%0d", k), rsp_valid, (k >= 5 && k <= 12));
            chk($sformatf("t1_last_c%0d", k), rsp_last, (k == 12));
            if (k == 13) begin
                chk("t1_req_ready", req_ready, 1'b1);
                chk("t1_burst_count", burst_count, 32'd1);
            end
            @(posedge clk); #1;
        end

        // Backpressure on alternate cycles.
        h0 = hs_cnt;
        do_req(32'h0000_0100);
        drain(1'b1);
        chk("bp_handshakes", hs_cnt - h0, 8);
        chk("bp_burst_count", burst_count, 32'd2);

        // Offset bits ignored and high bits wrap onto line 8.
        do_req(32'h0000_411C);
        drain(1'b0);
        chk("wrap_burst_count", burst_count, 32'd3);

        // Back-to-back with req_valid held high.
        push_line(32'h0000_0100);
        push_line(32'h0000_0200);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0100;
        acc = 0;
        for (int n = 0; n < 200 && acc < 2; n++) begin
            @(negedge clk);
            if (req_ready) begin
                if (acc == 1) chk("b2b_first_done", exp_q.size(), 8);
                acc++;
            end
            @(posedge clk); #1;
            if (acc == 1) req_addr = 32'h0000_0200;
        end
        req_valid = 1'b0;
        chk("b2b_accepts", acc, 2);
        drain(1'b0);
        chk("b2b_burst_count", burst_count, 32'd5);

        // Reset after the 3rd handshake.
        h0 = hs_cnt;
        do_req(32'h0000_0200);
        for (int n = 0; n < 50; n++) begin
            if (hs_cnt - h0 >= 3) break;
            @(posedge clk); #1;
        end
        chk("rst_mid_hs3", hs_cnt - h0, 3);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", rsp_valid, 1'b0);
        chk("mid_rst_last", rsp_last, 1'b0);
        chk("mid_rst_data", rsp_data, 32'd0);
        chk("mid_rst_burst_count", burst_count, 32'd0);
        chk("mid_rst_req_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_req(32'h0000_0200);
        drain(1'b0);
        chk("post_rst_handshakes", hs_cnt - h0, 11);
        chk("post_rst_burst_count", burst_count, 32'd1);

        // Latency-0 preload race on line 0x20 (words 0x100..0x107).
        req_valid0 = 1'b1;
        req_addr   = 32'h0000_0400;
        @(negedge clk);
        chk("race_req_ready", req_ready0, 1'b1);
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            init_wen  = (k <= 2);
            init_addr = (k == 1) ? 12'h101 : 12'h105;
            init_data = (k == 1) ? 32'hDEAD_0001 : 32'hDEAD_0005;
            if (init_wen) ref_mem[init_addr] = init_data;
            @(negedge clk);
            e = (k - 1 == 5) ? 32'hDEAD_0005 : 32'hB0 + 32'(k - 1);
            chk($sformatf("race_valid_b%0d", k - 1), rsp_valid0, 1'b1);
            chk($sformatf("race_data_b%0d", k - 1), rsp_data0, e);
            chk($sformatf("race_last_b%0d", k - 1), rsp_last0, (k == 8));
            @(posedge clk); #1;
        end
        init_wen = 1'b0;
        @(negedge clk);
        chk("race_done_valid", rsp_valid0, 1'b0);
        chk("race_done_ready", req_ready0, 1'b1);
        chk("race_burst_count", burst_count0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
